// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the flagged synchronous FIFO.
package fifo_pkg;

    localparam int FWFT_STANDARD = 0;
    localparam int FWFT_FALLTHRU = 1;

    // One extra pointer bit distinguishes full from empty when addresses match.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit thresh_valid(input int depth, input int afull, input int aempty);
        return (afull <= depth) && (aempty < depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read; contents are never reset.
module sync_fifo_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with full/empty/almost flags, sticky error flags, flush,
// and either a registered standard read or first-word-fall-through output.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int FWFT          = FWFT_STANDARD,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  rd_valid_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int PW    = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] AFULL_T  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_T = PW'(AEMPTY_THRESH);

    if (!thresh_valid(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_flags: AFULL_THRESH must be <= DEPTH and AEMPTY_THRESH < DEPTH");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [PW-1:0]         count_w;
    logic                  full_w, empty_w;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rdata_w;

    assign count_w = wr_ptr_q - rd_ptr_q;
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

    // Flush wins over any request in the same cycle.
    assign wr_acc = wr_en_i && !full_w  && !flush_i;
    assign rd_acc = rd_en_i && !empty_w && !flush_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d    = rd_ptr_q + PW'(rd_acc);
        overflow_d  = overflow_q  | (wr_en_i & full_w);
        underflow_d = underflow_q | (rd_en_i & empty_w);
        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (wr_acc),
        .waddr_i(wr_ptr_q[PW-2:0]),
        .wdata_i(din_i),
        .raddr_i(rd_ptr_q[PW-2:0]),
        .rdata_o(rdata_w)
    );

    if (FWFT == FWFT_STANDARD) begin : g_std
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  rd_valid_q, rd_valid_d;

        always_comb begin
            dout_d     = rd_acc ? rdata_w : dout_q;
            rd_valid_d = rd_acc;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                dout_q     <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                dout_q     <= dout_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign dout_o     = dout_q;
        assign rd_valid_o = rd_valid_q;
    end else begin : g_fwft
        // Head word is visible as soon as it is stored; rd_en only pops it.
        assign dout_o     = rdata_w;
        assign rd_valid_o = 1'b0;
    end

    assign full_o         = full_w;
    assign empty_o        = empty_w;
    assign count_o        = count_w;
    assign almost_full_o  = (count_w >= AFULL_T);
    assign almost_empty_o = (count_w <= AEMPTY_T);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench: standard-read FIFO plus a fall-through instance.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         errors = 0;

    logic       a_flush, a_wr, a_rd;
    logic [7:0] a_din, a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_rv, a_ov, a_un;
    logic [4:0] a_count;

    logic       b_flush, b_wr, b_rd;
    logic [7:0] b_din, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_rv, b_ov, b_un;
    logic [4:0] b_count;

    always #5 clk = ~clk;

    sync_fifo_flags #(.FWFT(0)) u_std (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .wr_en_i(a_wr), .din_i(a_din),
        .rd_en_i(a_rd), .dout_o(a_dout), .full_o(a_full), .empty_o(a_empty),
        .almost_full_o(a_af), .almost_empty_o(a_ae), .count_o(a_count),
        .rd_valid_o(a_rv), .overflow_o(a_ov), .underflow_o(a_un)
    );

    sync_fifo_flags #(.FWFT(1)) u_fwft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .wr_en_i(b_wr), .din_i(b_din),
        .rd_en_i(b_rd), .dout_o(b_dout), .full_o(b_full), .empty_o(b_empty),
        .almost_full_o(b_af), .almost_empty_o(b_ae), .count_o(b_count),
        .rd_valid_o(b_rv), .overflow_o(b_ov), .underflow_o(b_un)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_std(input string tag);
        chk({tag, "_count"}, 32'(a_count), 32'd0);
        chk({tag, "_empty"}, 32'(a_empty), 32'd1);
        chk({tag, "_full"},  32'(a_full),  32'd0);
        chk({tag, "_ae"},    32'(a_ae),    32'd1);
        chk({tag, "_af"},    32'(a_af),    32'd0);
        chk({tag, "_ov"},    32'(a_ov),    32'd0);
        chk({tag, "_un"},    32'(a_un),    32'd0);
        chk({tag, "_rv"},    32'(a_rv),    32'd0);
        chk({tag, "_dout"},  32'(a_dout),  32'd0);
    endtask

    int wr_idx;
    int rd_idx;

    initial begin
        rst_n = 1'b0;
        a_flush = 0; a_wr = 0; a_rd = 0; a_din = '0;
        b_flush = 0; b_wr = 0; b_rd = 0; b_din = '0;
        #12;
        chk_reset_std("reset");
        chk("reset_b_empty", 32'(b_empty), 32'd1);
        chk("reset_b_count", 32'(b_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Fall-through: word written into an empty FIFO is on dout right after the edge.
        b_wr = 1; b_din = 8'hA5;
        tick();
        b_wr = 0;
        chk("fwft_empty_after_wr", 32'(b_empty), 32'd0);
        chk("fwft_dout_a5",        32'(b_dout),  32'hA5);
        chk("fwft_count_1",        32'(b_count), 32'd1);
        chk("fwft_rd_valid_tied",  32'(b_rv),    32'd0);
        b_rd = 1;
        tick();
        b_rd = 0;
        chk("fwft_empty_after_pop", 32'(b_empty), 32'd1);
        chk("fwft_count_0",         32'(b_count), 32'd0);
        b_wr = 1; b_din = 8'h11;
        tick();
        b_din = 8'h22;
        tick();
        b_wr = 0;
        chk("fwft_head_11", 32'(b_dout), 32'h11);
        b_rd = 1;
        tick();
        b_rd = 0;
        chk("fwft_head_22", 32'(b_dout), 32'h22);
        chk("fwft_count_1b", 32'(b_count), 32'd1);

        // Fill the standard FIFO with 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            a_wr = 1; a_din = 8'(i);
            tick();
            chk($sformatf("fill_count_%0d", i), 32'(a_count), 32'(i + 1));
            chk($sformatf("fill_af_%0d", i),    32'(a_af),    32'((i + 1) >= 14));
            chk($sformatf("fill_ae_%0d", i),    32'(a_ae),    32'((i + 1) <= 2));
            chk($sformatf("fill_full_%0d", i),  32'(a_full),  32'((i + 1) == 16));
        end
        a_din = 8'hEE;
        tick();
        a_wr = 0;
        chk("ovf_count_16", 32'(a_count), 32'd16);
        chk("ovf_flag",     32'(a_ov),    32'd1);
        chk("ovf_full",     32'(a_full),  32'd1);

        // Drain: each word appears one cycle after its rd_en with a rd_valid pulse.
        for (int i = 0; i < 16; i++) begin
            a_rd = 1;
            tick();
            chk($sformatf("drain_dout_%0d", i),  32'(a_dout),  32'(i));
            chk($sformatf("drain_rv_%0d", i),    32'(a_rv),    32'd1);
            chk($sformatf("drain_count_%0d", i), 32'(a_count), 32'(15 - i));
        end
        a_rd = 0;
        chk("drain_empty", 32'(a_empty), 32'd1);
        tick();
        chk("idle_rv_low",   32'(a_rv),   32'd0);
        chk("idle_dout_hold", 32'(a_dout), 32'h0F);
        a_rd = 1;
        tick();
        a_rd = 0;
        chk("udf_flag",      32'(a_un),   32'd1);
        chk("udf_dout_hold", 32'(a_dout), 32'h0F);
        chk("udf_rv_low",    32'(a_rv),   32'd0);
        chk("udf_ov_sticky", 32'(a_ov),   32'd1);

        // Flush at count=10 with a concurrent write.
        for (int i = 0; i < 10; i++) begin
            a_wr = 1; a_din = 8'(8'h40 + i);
            tick();
        end
        chk("preflush_count", 32'(a_count), 32'd10);
        a_flush = 1; a_din = 8'h99;
        tick();
        a_flush = 0; a_wr = 0;
        chk("flush_count", 32'(a_count), 32'd0);
        chk("flush_empty", 32'(a_empty), 32'd1);
        chk("flush_ov",    32'(a_ov),    32'd0);
        chk("flush_un",    32'(a_un),    32'd0);
        chk("flush_rv",    32'(a_rv),    32'd0);
        a_wr = 1; a_din = 8'h55;
        tick();
        a_wr = 0; a_rd = 1;
        tick();
        a_rd = 0;
        chk("postflush_dout", 32'(a_dout), 32'h55);
        chk("postflush_count", 32'(a_count), 32'd0);

        // Simultaneous read/write at count=8 across several pointer wraps.
        wr_idx = 0; rd_idx = 0;
        for (int i = 0; i < 8; i++) begin
            a_wr = 1; a_din = 8'(8'h80 + wr_idx); wr_idx++;
            tick();
        end
        chk("simul_start_count", 32'(a_count), 32'd8);
        for (int i = 0; i < 40; i++) begin
            a_wr = 1; a_rd = 1; a_din = 8'(8'h80 + wr_idx); wr_idx++;
            tick();
            chk($sformatf("simul_count_%0d", i), 32'(a_count), 32'd8);
            chk($sformatf("simul_dout_%0d", i),  32'(a_dout),  32'(8'(8'h80 + rd_idx)));
            rd_idx++;
        end
        a_wr = 0;
        for (int i = 0; i < 3; i++) begin
            a_rd = 1;
            tick();
            chk($sformatf("tail_dout_%0d", i), 32'(a_dout), 32'(8'(8'h80 + rd_idx)));
            rd_idx++;
        end
        a_rd = 0;
        chk("premrst_count", 32'(a_count), 32'd5);

        // Asynchronous reset mid-burst, between clock edges.
        a_wr = 1; a_din = 8'hC3;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_std("async_rst");
        a_wr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        a_wr = 1; a_din = 8'h3C;
        tick();
        a_wr = 0; a_rd = 1;
        tick();
        a_rd = 0;
        chk("postrst_dout",  32'(a_dout),  32'h3C);
        chk("postrst_rv",    32'(a_rv),    32'd1);
        chk("postrst_count", 32'(a_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
